// File: rtl/cmsdk_mcu_mtx4x2_outarb_m0.sv
// M0 output stage of the 4x2 AHB bus matrix: round-robin arbitration across the input ports,
// with burst/lock hold, address-phase muxing and data-phase write-data muxing.
module cmsdk_mcu_mtx4x2_outarb_m0 #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned AW     = 32
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_IN-1:0]   sel_op,
    input  logic [NUM_IN*AW-1:0] addr_op,
    input  logic [2*NUM_IN-1:0] trans_op,
    input  logic [NUM_IN-1:0]   write_op,
    input  logic [3*NUM_IN-1:0] size_op,
    input  logic [3*NUM_IN-1:0] burst_op,
    input  logic [4*NUM_IN-1:0] prot_op,
    input  logic [NUM_IN-1:0]   mastlock_op,
    input  logic [32*NUM_IN-1:0] wdata_op,
    input  logic                HREADYM,
    output logic [NUM_IN-1:0]   active_op,
    output logic                HSELM,
    output logic [AW-1:0]       HADDRM,
    output logic [1:0]          HTRANSM,
    output logic                HWRITEM,
    output logic [2:0]          HSIZEM,
    output logic [2:0]          HBURSTM,
    output logic [3:0]          HPROTM,
    output logic                HMASTLOCKM,
    output logic [1:0]          HMASTERM,
    output logic [31:0]         HWDATAM
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonSeq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstIncr   = 3'b001;

    logic [1:0] addr_in_port_q, addr_in_port_d;
    logic       no_port_q, no_port_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] data_in_port_q, data_in_port_d;

    logic [NUM_IN-1:0] req;
    logic [31:0]       g_idx, d_idx;
    logic [1:0]        g_trans;
    logic [2:0]        g_burst;
    logic [3:0]        len_m1;
    logic              fixed_burst;
    logic              hold;
    logic              rr_found;
    logic [1:0]        rr_port;
    logic [1:0]        scan_idx;
    logic              grant_chg;

    always_comb begin
        for (int i = 0; i < int'(NUM_IN); i++) begin
            req[i] = sel_op[i] & trans_op[2*i+1];
        end
    end

    assign g_idx   = {30'd0, addr_in_port_q};
    assign d_idx   = {30'd0, data_in_port_q};
    assign g_trans = trans_op[2*g_idx +: 2];
    assign g_burst = burst_op[3*g_idx +: 3];

    assign HSELM      = ~no_port_q & sel_op[addr_in_port_q];
    assign HTRANSM    = HSELM ? g_trans : TransIdle;
    assign HMASTLOCKM = HSELM & mastlock_op[addr_in_port_q];
    assign HMASTERM   = addr_in_port_q;
    assign HADDRM     = addr_op[AW*g_idx +: AW];
    assign HWRITEM    = write_op[addr_in_port_q];
    assign HSIZEM     = size_op[3*g_idx +: 3];
    assign HBURSTM    = g_burst;
    assign HPROTM     = prot_op[4*g_idx +: 4];
    assign HWDATAM    = wdata_op[32*d_idx +: 32];
    assign active_op  = no_port_q ? '0 : (NUM_IN'(1) << addr_in_port_q);

    // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE and INCR.
    always_comb begin
        len_m1 = 4'd0;
        unique case (g_burst[2:1])
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            2'b11:   len_m1 = 4'd15;
            default: len_m1 = 4'd0;
        endcase
    end

    assign fixed_burst = (g_burst[2:1] != 2'b00);

    assign hold = HMASTLOCKM
                | (HSELM & (g_trans == TransBusy))
                | (HSELM & (g_burst == BurstIncr) & g_trans[1])
                | (HSELM & fixed_burst &
                   (((g_trans == TransNonSeq) & (len_m1 > 4'd1)) |
                    ((g_trans == TransSeq) & (beat_cnt_q > 4'd1))));

    // Scan starts one past the last grant; the last grantee is checked last.
    always_comb begin
        rr_found = 1'b0;
        rr_port  = addr_in_port_q;
        scan_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_grant_q + 2'(k);
            if (!rr_found && req[scan_idx]) begin
                rr_found = 1'b1;
                rr_port  = scan_idx;
            end
        end
    end

    always_comb begin
        addr_in_port_d = addr_in_port_q;
        no_port_d      = no_port_q;
        last_grant_d   = last_grant_q;
        beat_cnt_d     = beat_cnt_q;
        data_in_port_d = data_in_port_q;
        grant_chg      = 1'b0;
        if (HREADYM) begin
            data_in_port_d = addr_in_port_q;
            if (!hold) begin
                if (rr_found) begin
                    addr_in_port_d = rr_port;
                    last_grant_d   = rr_port;
                    no_port_d      = 1'b0;
                end else begin
                    no_port_d = 1'b1;
                end
            end
            grant_chg = (addr_in_port_d != addr_in_port_q) || (no_port_d != no_port_q);
            if (!HSELM || grant_chg) begin
                beat_cnt_d = 4'd0;
            end else if (g_trans == TransNonSeq) begin
                beat_cnt_d = len_m1;
            end else if ((g_trans == TransSeq) && (beat_cnt_q != 4'd0)) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_in_port_q <= 2'd0;
            no_port_q      <= 1'b1;
            last_grant_q   <= 2'd3;
            beat_cnt_q     <= 4'd0;
            data_in_port_q <= 2'd0;
        end else begin
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
            last_grant_q   <= last_grant_d;
            beat_cnt_q     <= beat_cnt_d;
            data_in_port_q <= data_in_port_d;
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_mtx4x2_outarb_m0.sv
// Directed bench for the M0 output arbiter: a per-cycle vector table plus an async reset sequence.
module tb_cmsdk_mcu_mtx4x2_outarb_m0;

    logic         HCLK;
    logic         HRESET;
    logic [3:0]   sel_op;
    logic [127:0] addr_op;
    logic [7:0]   trans_op;
    logic [3:0]   write_op;
    logic [11:0]  size_op;
    logic [11:0]  burst_op;
    logic [15:0]  prot_op;
    logic [3:0]   mastlock_op;
    logic [127:0] wdata_op;
    logic         HREADYM;
    logic [3:0]   active_op;
    logic         HSELM;
    logic [31:0]  HADDRM;
    logic [1:0]   HTRANSM;
    logic         HWRITEM;
    logic [2:0]   HSIZEM;
    logic [2:0]   HBURSTM;
    logic [3:0]   HPROTM;
    logic         HMASTLOCKM;
    logic [1:0]   HMASTERM;
    logic [31:0]  HWDATAM;

    int checks = 0;
    int errors = 0;

    cmsdk_mcu_mtx4x2_outarb_m0 dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .sel_op      (sel_op),
        .addr_op     (addr_op),
        .trans_op    (trans_op),
        .write_op    (write_op),
        .size_op     (size_op),
        .burst_op    (burst_op),
        .prot_op     (prot_op),
        .mastlock_op (mastlock_op),
        .wdata_op    (wdata_op),
        .HREADYM     (HREADYM),
        .active_op   (active_op),
        .HSELM       (HSELM),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HWRITEM     (HWRITEM),
        .HSIZEM      (HSIZEM),
        .HBURSTM     (HBURSTM),
        .HPROTM      (HPROTM),
        .HMASTLOCKM  (HMASTLOCKM),
        .HMASTERM    (HMASTERM),
        .HWDATAM     (HWDATAM)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  trans;
        logic [11:0] burst;
        logic [3:0]  lock;
        logic        rdy;
        logic [3:0]  e_act;
        logic        e_sel;
        logic [1:0]  e_trans;
        logic [1:0]  e_mst;
        logic [1:0]  e_wown;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] sel, input logic [7:0] trans,
                                input logic [11:0] burst, input logic [3:0] lock,
                                input logic rdy, input logic [3:0] e_act, input logic e_sel,
                                input logic [1:0] e_trans, input logic [1:0] e_mst,
                                input logic [1:0] e_wown);
        vec_t v;
        v.sel = sel; v.trans = trans; v.burst = burst; v.lock = lock; v.rdy = rdy;
        v.e_act = e_act; v.e_sel = e_sel; v.e_trans = e_trans; v.e_mst = e_mst;
        v.e_wown = e_wown;
        return v;
    endfunction

    function automatic logic [31:0] port_addr(input logic [1:0] p);
        return 32'hA000_0000 | ({30'd0, p} << 8);
    endfunction

    function automatic logic [31:0] port_wdata(input logic [1:0] p);
        return 32'hD0D0_0000 | {30'd0, p};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] e_act, input logic e_sel,
                               input logic [1:0] e_trans, input logic [1:0] e_mst,
                               input logic [1:0] e_wown);
        chk({tag, " active_op"}, {28'd0, active_op}, {28'd0, e_act});
        chk({tag, " HSELM"}, {31'd0, HSELM}, {31'd0, e_sel});
        chk({tag, " HTRANSM"}, {30'd0, HTRANSM}, {30'd0, e_trans});
        chk({tag, " HMASTERM"}, {30'd0, HMASTERM}, {30'd0, e_mst});
        chk({tag, " HADDRM"}, HADDRM, port_addr(e_mst));
        chk({tag, " HWDATAM"}, HWDATAM, port_wdata(e_wown));
    endtask

    initial begin
        HRESET      = 1'b1;
        sel_op      = '0;
        trans_op    = '0;
        burst_op    = '0;
        mastlock_op = '0;
        HREADYM     = 1'b1;
        write_op    = 4'b0101;
        size_op     = 12'o2222;
        prot_op     = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            addr_op[32*i +: 32]  = port_addr(2'(i));
            wdata_op[32*i +: 32] = port_wdata(2'(i));
        end

        // Ports 1 (INCR) and 3 (SINGLE) request together.
        vecs.push_back(mk(4'b1010, 8'h88, 12'h008, 4'h0, 1, 4'b0000, 0, 2'b00, 2'd0, 2'd0));
        vecs.push_back(mk(4'b1010, 8'h88, 12'h008, 4'h0, 1, 4'b0010, 1, 2'b10, 2'd1, 2'd0));
        vecs.push_back(mk(4'b1010, 8'h8C, 12'h008, 4'h0, 1, 4'b0010, 1, 2'b11, 2'd1, 2'd1));
        vecs.push_back(mk(4'b1010, 8'h80, 12'h008, 4'h0, 1, 4'b0010, 1, 2'b00, 2'd1, 2'd1));
        vecs.push_back(mk(4'b1000, 8'h80, 12'h000, 4'h0, 1, 4'b1000, 1, 2'b10, 2'd3, 2'd1));
        vecs.push_back(mk(4'b0000, 8'h00, 12'h000, 4'h0, 1, 4'b1000, 0, 2'b00, 2'd3, 2'd3));
        vecs.push_back(mk(4'b0000, 8'h00, 12'h000, 4'h0, 1, 4'b0000, 0, 2'b00, 2'd3, 2'd3));
        // Port 0 INCR4 while ports 1..3 request.
        vecs.push_back(mk(4'b1111, 8'hAA, 12'h003, 4'h0, 1, 4'b0000, 0, 2'b00, 2'd3, 2'd3));
        vecs.push_back(mk(4'b1111, 8'hAA, 12'h003, 4'h0, 1, 4'b0001, 1, 2'b10, 2'd0, 2'd3));
        vecs.push_back(mk(4'b1111, 8'hAB, 12'h003, 4'h0, 1, 4'b0001, 1, 2'b11, 2'd0, 2'd0));
        vecs.push_back(mk(4'b1111, 8'hAB, 12'h003, 4'h0, 1, 4'b0001, 1, 2'b11, 2'd0, 2'd0));
        vecs.push_back(mk(4'b1111, 8'hAB, 12'h003, 4'h0, 1, 4'b0001, 1, 2'b11, 2'd0, 2'd0));
        vecs.push_back(mk(4'b1110, 8'hA8, 12'h0C0, 4'h0, 1, 4'b0010, 1, 2'b10, 2'd1, 2'd0));
        // Port 2 INCR4 with three wait states on its second beat.
        vecs.push_back(mk(4'b1100, 8'hA0, 12'h0C0, 4'h0, 1, 4'b0100, 1, 2'b10, 2'd2, 2'd1));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 0, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 0, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 0, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 1, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 1, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        vecs.push_back(mk(4'b1100, 8'hB0, 12'h0C0, 4'h0, 1, 4'b0100, 1, 2'b11, 2'd2, 2'd2));
        // Port 3 locked across two SINGLEs while port 0 requests.
        vecs.push_back(mk(4'b1001, 8'h82, 12'h000, 4'h8, 1, 4'b1000, 1, 2'b10, 2'd3, 2'd2));
        vecs.push_back(mk(4'b1001, 8'h82, 12'h000, 4'h8, 1, 4'b1000, 1, 2'b10, 2'd3, 2'd3));
        vecs.push_back(mk(4'b0001, 8'h02, 12'h000, 4'h0, 1, 4'b1000, 0, 2'b00, 2'd3, 2'd3));
        vecs.push_back(mk(4'b0001, 8'h02, 12'h000, 4'h0, 1, 4'b0001, 1, 2'b10, 2'd0, 2'd3));
        vecs.push_back(mk(4'b0000, 8'h00, 12'h000, 4'h0, 1, 4'b0001, 0, 2'b00, 2'd0, 2'd0));
        vecs.push_back(mk(4'b0000, 8'h00, 12'h000, 4'h0, 1, 4'b0000, 0, 2'b00, 2'd0, 2'd0));

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        chk_outputs("reset", 4'b0000, 1'b0, 2'b00, 2'd0, 2'd0);
        chk("reset HMASTLOCKM", {31'd0, HMASTLOCKM}, 32'd0);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge HCLK);
            sel_op      = vecs[n].sel;
            trans_op    = vecs[n].trans;
            burst_op    = vecs[n].burst;
            mastlock_op = vecs[n].lock;
            HREADYM     = vecs[n].rdy;
            #1;
            chk_outputs($sformatf("vec%0d", n), vecs[n].e_act, vecs[n].e_sel,
                        vecs[n].e_trans, vecs[n].e_mst, vecs[n].e_wown);
        end

        // Port 1 INCR8 interrupted by reset on beat 2; port 0 requests throughout.
        @(negedge HCLK);
        sel_op = 4'b0011; trans_op = 8'h0A; burst_op = 12'h028; HREADYM = 1'b1;
        @(negedge HCLK);
        #1;
        chk("rst_seq grant p1", {28'd0, active_op}, 32'h2);
        @(negedge HCLK);
        trans_op = 8'h0E;
        #1;
        chk("rst_seq beat2 HTRANSM", {30'd0, HTRANSM}, 32'h3);
        HRESET = 1'b1;
        #1;
        chk("rst_seq async active_op", {28'd0, active_op}, 32'h0);
        chk("rst_seq async HTRANSM", {30'd0, HTRANSM}, 32'h0);
        chk("rst_seq async HMASTERM", {30'd0, HMASTERM}, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        trans_op = 8'h0A;
        #1;
        chk("rst_seq post-release idle", {28'd0, active_op}, 32'h0);
        @(negedge HCLK);
        #1;
        chk("rst_seq p0 wins active_op", {28'd0, active_op}, 32'h1);
        chk("rst_seq p0 wins HMASTERM", {30'd0, HMASTERM}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmsdk_mcu_mtx4x2_outarb_m0.md
# cmsdk_mcu_mtx4x2_outarb_M0

Output stage for output port M0 of the 4x2 AHB bus matrix. It is the far end of the input-port address decoders: it collects the per-input-port select/transfer requests that the decoders steer toward M0, arbitrates among up to four input ports with round-robin priority, and drives the M0 AHB master interface. Arbitration respects fixed-length bursts, undefined-length INCR bursts and locked sequences. It feeds `active_op` back to each input stage and muxes write data in the data phase.

## Interface
Parameters:
- NUM_IN, 4, number of input ports. Fixed; index width 2.
- AW, 32, address width.

Ports. Per-port buses are flattened; port i occupies slice i.
- HCLK  in  1  AHB clock.
- HRESET  in  1  Reset. One clock; reset is asynchronous and active-high.
- sel_op  in  4  Decoder select toward M0, one bit per input port.
- addr_op  in  4*AW  HADDR per port; port i at [AW*i+AW-1:AW*i].
- trans_op  in  8  HTRANS per port.
- write_op  in  4  HWRITE per port.
- size_op  in  12  HSIZE per port.
- burst_op  in  12  HBURST per port.
- prot_op  in  16  HPROT per port.
- mastlock_op  in  4  HMASTLOCK per port.
- wdata_op  in  128  HWDATA per port.
- HREADYM  in  1  HREADY returned from the M0 slave side.
- active_op  out  4  One-hot address-phase grant to each input stage.
- HSELM  out  1
- HADDRM  out  AW
- HTRANSM  out  2
- HWRITEM  out  1
- HSIZEM  out  3
- HBURSTM  out  3
- HPROTM  out  4
- HMASTLOCKM  out  1
- HMASTERM  out  2  Index of the granted input port.
- HWDATAM  out  32  Write data of the data-phase owner.

## Operation
Definitions:
- req[i] = sel_op[i] & trans_op[i][1] (NONSEQ or SEQ).
- Registered state: addr_in_port[1:0], no_port, last_grant[1:0], beat_cnt[3:0], data_in_port[1:0].

Address-phase outputs:
- Muxed from port addr_in_port.
- HSELM = ~no_port & sel_op[g].
- HTRANSM = HSELM ? trans_op[g] : IDLE.
- HMASTLOCKM = HSELM & mastlock_op[g].
- HMASTERM = addr_in_port.
- active_op = no_port ? 0 : one-hot(addr_in_port).

Hold condition, evaluated for the granted port g (hold = 1 keeps the grant):
- HMASTLOCKM = 1; or
- HSELM and trans = BUSY; or
- HSELM, burst = INCR, and trans is NONSEQ or SEQ. An INCR owner keeps the grant until it issues IDLE or drops sel. Starvation is accepted.
- HSELM, fixed burst (INCR/WRAP 4/8/16): NONSEQ with length > 1, or SEQ with beat_cnt > 1.

Arbitration, only when HREADYM = 1:
- If hold: grant unchanged.
- Otherwise: scan req starting at last_grant+1 mod 4. The first hit becomes addr_in_port and last_grant, and no_port is cleared.
- No hit: no_port = 1; addr_in_port and last_grant retained.

beat_cnt update, on HREADYM = 1:
- Accepted NONSEQ: length-1 (3/7/15; 0 for SINGLE or INCR).
- Accepted SEQ: decrement, saturating at 0.
- Grant change or HSELM = 0: cleared.

Data phase:
- On HREADYM = 1: data_in_port <= addr_in_port.
- HWDATAM = wdata_op[data_in_port].

Reset values:
- addr_in_port = 0, no_port = 1, last_grant = 3 (port 0 has first priority), beat_cnt = 0, data_in_port = 0.
- Hence active_op = 0, HSELM = 0, HTRANSM = IDLE, HMASTLOCKM = 0, HMASTERM = 0.
- HADDRM, HWRITEM, HSIZEM, HBURSTM and HPROTM follow port 0. HWDATAM = wdata_op[31:0].

## Timing
- Arbitration latency is one cycle. A request sampled with HREADYM = 1 at edge n appears on HTRANSM and active_op after edge n. The input stage holds its transfer until it sees active_op.
- HREADYM = 0 freezes all state, so the grant and the data-phase owner are stable across wait states.
- Owner drops sel mid fixed burst: hold is released, beat_cnt is cleared, and the port re-arbitrates at the next HREADYM.
- Simultaneous requests: round-robin order only. Lock outranks everything.
- Reset asserted mid-burst: all state returns to reset values immediately (asynchronous). The first grant after release follows the reset priority.

## Test plan
- Reset, then req on ports 1 and 3 simultaneously with HREADYM = 1 -> port 1 granted the next cycle (active_op = 0010, HMASTERM = 1); port 3 granted after port 1 issues IDLE.
- Port 0 INCR4 with ports 1–3 requesting and HREADYM = 1 throughout -> four consecutive beats on M0 with grant held; port 1 granted on the cycle after the fourth beat.
- Port 2 issues an INCR4 beat while HREADYM is low for 3 cycles -> HADDRM, active_op, HWDATAM owner and beat_cnt unchanged during the wait states.
- Port 3 with mastlock asserted across two SINGLE transfers while port 0 requests -> port 0 never granted until mastlock drops.
- All req low -> HSELM = 0, HTRANSM = 00, active_op = 0000. A write from port 2 -> HWDATAM = wdata_op of port 2 in the data phase.
- HRESET pulsed during beat 2 of a port 1 INCR8 -> active_op = 0000 and HTRANSM = 00 asynchronously. After release, port 0 wins if it is requesting.
